seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
// Display-side receiver for the 4-digit multiplexed seven-segment bus (active-low an/seg).
// Watches the anode scan, waits for each digit's pattern to settle, decodes it back to BCD,
// and publishes a complete 4-digit word once all four digits are captured in one frame.
// Used as a loop-back checker and as a front end for capturing display-driver output.
// PARAMETERS
// SETTLE_CYCLES   4     consecutive identical samples required before a digit is captured (>=2)
// TIMEOUT_CYCLES  4096  max cycles from first capture to frame completion before the frame is discarded
// PORTS
// clk            in   1   system clock, all logic on rising edge
// reset          in   1   asynchronous, active-high; clears all state
// an             in   4   anode selects, active-low; exactly one low = digit an[i] is driven
// seg            in   7   cathodes, active-low; seg[6]=a ... seg[0]=g
// digits         out  16  {d3,d2,d1,d0}; d[i] is 4-bit code for anode i; updated only at frame end
// frame_valid    out  1   one-cycle pulse, same cycle digits/digit_err update
// digit_err      out  4   per-digit flag: pattern was not 0-9 or blank; valid with digits
// frame_timeout  out  1   one-cycle pulse when a partial frame is discarded
// BEHAVIOUR
// - Reset (async): digits=16'hFFFF, digit_err=0, frame_valid=0, frame_timeout=0, state=IDLE,
//   cnt=0, mask=0, shadow regs=4'hF each, timer=0. Inputs are synchronous to clk.
// - Decode (active-low, a..g): 0000001->0 1001111->1 0010010->2 0000110->3 1001100->4
//   0100100->5 0100000->6 0001111->7 0000000->8 0000100->9; 1111111 (blank)->4'hF, no error;
//   any other pattern -> 4'hE with error bit set.
// - Legal select: an in {1110,1101,1011,0111} -> index 0..3. Any other an value is illegal.
// - Sampler: prev register holds {an,seg} from last edge. cnt=0 on any change, else cnt+1
//   (saturating at SETTLE_CYCLES-1). Pair is "settled" when cnt==SETTLE_CYCLES-1 with an legal.
// - FSM states: IDLE, SETTLE, CAPTURE, HOLD.
//   IDLE: an legal -> SETTLE. Stay otherwise.
//   SETTLE: illegal an -> IDLE; pair changed -> stay, cnt restarts; settled -> CAPTURE.
//   CAPTURE (1 cycle): shadow[idx]<=decode(seg), err_sh[idx]<=bad, mask[idx]<=1 -> HOLD.
//   HOLD: stay while pair unchanged (one capture per stable period); change -> IDLE if an
//   illegal else SETTLE with cnt=0.
// - Latency: capture is written on the edge after the settled edge; minimum
//   SETTLE_CYCLES+1 edges from an/seg change to shadow update.
// - Re-capture of same index before frame end overwrites shadow/err_sh; mask unchanged.
// - Frame end: on the edge where mask becomes 4'b1111: digits<=shadow (with new capture),
//   digit_err<=err_sh, frame_valid=1 for that cycle, mask<=0, timer<=0. Scan order irrelevant.
// - Timeout: timer runs while mask!=0; at timer==TIMEOUT_CYCLES-1 without completion:
//   mask<=0, timer<=0, frame_timeout pulse, digits/digit_err unchanged. If completion and
//   timeout coincide, completion wins, no timeout pulse.
// - Illegal an never alters mask, shadow or outputs; only resets sampler/FSM to IDLE.
// - Reset mid-frame discards partial frame; no pulses emitted during or after reset.
// - frame_valid and frame_timeout never assert in the same cycle.
// TESTING
// 1 Reset: assert reset mid-SETTLE -> digits=FFFF, digit_err=0, pulses 0, next frame starts clean.
// 2 Scan an=1110/1101/1011/0111 with 0000110,0000001,1001111,0000100, each held 8 cycles
//   -> one frame_valid, digits=16'h9103, digit_err=0.
// 3 Hold a digit SETTLE_CYCLES-2 cycles then change seg -> no capture; held 4 cycles -> capture.
// 4 Digit 2 pattern 1111110 (illegal), digit 1 blank -> digits[11:8]=E, digit_err=0100,
//   digits[7:4]=F.
// 5 an=1100 or 1111 between digits -> no capture, mask unchanged; frame still completes.
// 6 Capture digits 0-2 only, wait TIMEOUT_CYCLES -> frame_timeout pulse, digits unchanged;
//   digit 0 re-driven 5 then 7 in same frame -> final d0=7.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receiver for a 4-digit multiplexed active-low seven-segment bus: waits for each digit to
// settle, decodes it back to BCD and publishes a complete 4-digit word once per frame.
//
// state    | meaning
// IDLE     | no legal anode selected, waiting for one
// SETTLE   | legal anode seen, waiting for {an,seg} to stay stable
// CAPTURE  | write the settled digit into its shadow slot (one cycle)
// HOLD     | digit captured, waiting for the bus to move on
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic        frame_timeout
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic an_legal(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: an_legal = 1'b1;
      default:                            an_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] a);
    case (a)
      4'b1101: an_index = 2'd1;
      4'b1011: an_index = 2'd2;
      4'b0111: an_index = 2'd3;
      default: an_index = 2'd0;
    endcase
  endfunction

  // returns {bad, code}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: seg_decode = 5'h00;
      7'b1001111: seg_decode = 5'h01;
      7'b0010010: seg_decode = 5'h02;
      7'b0000110: seg_decode = 5'h03;
      7'b1001100: seg_decode = 5'h04;
      7'b0100100: seg_decode = 5'h05;
      7'b0100000: seg_decode = 5'h06;
      7'b0001111: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0000100: seg_decode = 5'h09;
      7'b1111111: seg_decode = 5'h0F;
      default:    seg_decode = 5'h1E;
    endcase
  endfunction

  logic [10:0]   pair_now;
  logic [10:0]   prev;
  logic [10:0]   cap_pair;
  logic [CW-1:0] cnt;
  logic          changed;
  logic          settled;
  logic [1:0]    state;
  logic [1:0]    state_nxt;

  assign pair_now = {an, seg};
  assign changed  = (pair_now != prev);
  // prev still holds the stable pair even if the bus moves on this very edge
  assign settled  = (cnt == CNT_MAX) && an_legal(prev[10:7]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= pair_now;
      if (changed)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (an_legal(an)) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (settled)
          state_nxt = ST_CAPTURE;
        else if (!an_legal(an))
          state_nxt = ST_IDLE;
      end
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (pair_now != cap_pair)
          state_nxt = an_legal(an) ? ST_SETTLE : ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cap_pair <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_SETTLE && settled)
        cap_pair <= prev;
    end
  end

  logic        capture_en;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_dec;
  logic [15:0] shadow;
  logic [15:0] shadow_nx;
  logic [3:0]  err_sh;
  logic [3:0]  err_nx;
  logic [3:0]  mask;
  logic [3:0]  mask_nx;
  logic [TW-1:0] timer;
  logic        complete;

  assign capture_en = (state == ST_CAPTURE);
  assign cap_idx    = an_index(cap_pair[10:7]);
  assign cap_dec    = seg_decode(cap_pair[6:0]);

  always_comb begin
    shadow_nx = shadow;
    err_nx    = err_sh;
    mask_nx   = mask;
    if (capture_en) begin
      shadow_nx[{cap_idx, 2'b00} +: 4] = cap_dec[3:0];
      err_nx[cap_idx]                  = cap_dec[4];
      mask_nx[cap_idx]                 = 1'b1;
    end
  end

  assign complete = capture_en && (mask_nx == 4'hF);

  // completion takes priority over a coinciding timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow        <= 16'hFFFF;
      err_sh        <= '0;
      mask          <= '0;
      timer         <= '0;
      digits        <= 16'hFFFF;
      digit_err     <= '0;
      frame_valid   <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      frame_valid   <= 1'b0;
      frame_timeout <= 1'b0;
      shadow        <= shadow_nx;
      err_sh        <= err_nx;
      if (complete) begin
        digits      <= shadow_nx;
        digit_err   <= err_nx;
        frame_valid <= 1'b1;
        mask        <= '0;
        timer       <= '0;
      end else if (mask != 4'h0 && timer == TMR_MAX) begin
        frame_timeout <= 1'b1;
        mask          <= '0;
        timer         <= '0;
      end else begin
        mask <= mask_nx;
        if (mask != 4'h0)
          timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scan scenarios plus randomized holds,
// checked against a frame-level model of the display bus.
module tb_seg7_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic        frame_timeout;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg),
    .digits(digits), .frame_valid(frame_valid),
    .digit_err(digit_err), .frame_timeout(frame_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_timeout;
    logic [15:0] digits;
    logic [3:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // frame-level model
  logic [3:0]  m_code[4];
  bit          m_bad[4];
  bit          m_have[4];
  logic [15:0] m_digits;
  logic [3:0]  m_err_out;
  logic [10:0] last_pair;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [3:0] an_of(input int idx);
    logic [3:0] one;
    one = 4'b0001 << idx;
    return ~one;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_have[i] = 1'b0;
      m_code[i] = 4'hF;
      m_bad[i]  = 1'b0;
    end
    m_digits  = 16'hFFFF;
    m_err_out = 4'h0;
    exp_q.delete();
  endtask

  task automatic model_capture(input int idx, input logic [6:0] s);
    logic [3:0] code;
    bit         bad;
    code = 4'hE;
    bad  = 1'b1;
    if (s == 7'h7F) begin
      code = 4'hF;
      bad  = 1'b0;
    end
    for (int i = 0; i < 10; i++)
      if (s == seg_tab[i]) begin
        code = 4'(i);
        bad  = 1'b0;
      end
    m_code[idx] = code;
    m_bad[idx]  = bad;
    m_have[idx] = 1'b1;
    if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
      exp_t e;
      m_digits  = {m_code[3], m_code[2], m_code[1], m_code[0]};
      m_err_out = {m_bad[3], m_bad[2], m_bad[1], m_bad[0]};
      e.is_timeout = 1'b0;
      e.digits     = m_digits;
      e.err        = m_err_out;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
    end
  endtask

  // drive a pair for n edges; a legal pair held SETTLE or more edges is one capture
  task automatic hold_pair(input logic [3:0] a, input logic [6:0] s, input int n);
    int idx;
    if ($countones(~a) == 1 && n >= SETTLE) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      model_capture(idx, s);
    end
    an = a;
    seg = s;
    last_pair = {a, s};
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n);
    if (n >= TIMEOUT + 64 && (m_have[0] || m_have[1] || m_have[2] || m_have[3])) begin
      exp_t e;
      e.is_timeout = 1'b1;
      e.digits     = m_digits;
      e.err        = m_err_out;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
    end
    hold_pair(4'hF, 7'h7F, n);
  endtask

  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_timeout)) begin
      check("pulse_exclusive", 16'(frame_valid & frame_timeout), 16'h0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: actual valid=%b timeout=%b digits=%h required no pulse",
                 frame_valid, frame_timeout, digits);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 16'(frame_timeout), 16'(mon_e.is_timeout));
        check("frame_digits", digits, mon_e.digits);
        check("frame_err", 16'(digit_err), 16'(mon_e.err));
      end
    end
  end

  task automatic random_round();
    int k;
    logic [3:0] a;
    logic [6:0] s;
    int n;
    bit missing[4];
    k = $urandom_range(3, 10);
    for (int h = 0; h < k; h++) begin
      do begin
        if ($urandom_range(0, 99) < 80) begin
          a = an_of($urandom_range(0, 3));
          case ($urandom_range(0, 9))
            0: s = 7'h7F;
            1: begin
              do s = 7'($urandom_range(0, 126));
              while (s inside {seg_tab});
            end
            default: s = seg_tab[$urandom_range(0, 9)];
          endcase
        end else begin
          do a = 4'($urandom_range(0, 15));
          while ($countones(~a) == 1);
          s = 7'($urandom);
        end
      end while ({a, s} == last_pair);
      n = ($urandom_range(0, 99) < 30) ? $urandom_range(2, 3) : $urandom_range(6, 12);
      hold_pair(a, s, n);
    end
    for (int i = 0; i < 4; i++) missing[i] = !m_have[i] && (m_have[0] || m_have[1] || m_have[2] || m_have[3]);
    for (int i = 0; i < 4; i++)
      if (missing[i]) hold_pair(an_of(i), seg_tab[$urandom_range(0, 9)], 8);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    last_pair = 11'h7FF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_digits", digits, 16'hFFFF);
    check("reset_err", 16'(digit_err), 16'h0);
    check("reset_pulses", 16'({frame_valid, frame_timeout}), 16'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // reset asserted while a digit is settling
    hold_pair(4'b1101, 7'b0100100, 2);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("midreset_digits", digits, 16'hFFFF);
    check("midreset_pulses", 16'({frame_valid, frame_timeout}), 16'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // basic scan
    hold_pair(4'b1110, 7'b0000110, 8);
    hold_pair(4'b1101, 7'b0000001, 8);
    hold_pair(4'b1011, 7'b1001111, 8);
    hold_pair(4'b0111, 7'b0000100, 8);
    repeat (2) @(posedge clk);
    #1;
    check("scan_digits", digits, 16'h9103);
    check("scan_err", 16'(digit_err), 16'h0);

    // settle boundary: 4 edges captures, 2 edges does not
    hold_pair(4'b1110, seg_tab[6], 4);
    hold_pair(4'b1101, seg_tab[5], 8);
    hold_pair(4'b1011, seg_tab[7], 8);
    hold_pair(4'b0111, seg_tab[2], 2);
    idle_wait(8);
    check("short_hold_no_frame", digits, 16'h9103);
    hold_pair(4'b0111, seg_tab[8], 8);
    repeat (2) @(posedge clk);
    #1;
    check("settle_digits", digits, 16'h8756);

    // bad pattern and blank
    hold_pair(4'b1110, seg_tab[0], 8);
    hold_pair(4'b1101, 7'b1111111, 8);
    hold_pair(4'b1011, 7'b1111110, 8);
    hold_pair(4'b0111, seg_tab[1], 8);
    repeat (2) @(posedge clk);
    #1;
    check("bad_d2", 16'(digits[11:8]), 16'hE);
    check("blank_d1", 16'(digits[7:4]), 16'hF);
    check("bad_err", 16'(digit_err), 16'b0100);

    // illegal selects between digits
    hold_pair(4'b1110, seg_tab[4], 8);
    hold_pair(4'b1100, seg_tab[9], 6);
    hold_pair(4'b1101, seg_tab[3], 8);
    hold_pair(4'b1111, seg_tab[0], 6);
    hold_pair(4'b1011, seg_tab[2], 8);
    check("illegal_mid_frame", digits, 16'h1EF0);
    hold_pair(4'b1100, seg_tab[8], 6);
    hold_pair(4'b0111, seg_tab[1], 8);
    repeat (2) @(posedge clk);
    #1;
    check("illegal_digits", digits, 16'h1234);

    // partial frame timeout, then re-capture of digit 0 within one frame
    hold_pair(4'b1110, seg_tab[9], 8);
    hold_pair(4'b1101, seg_tab[9], 8);
    hold_pair(4'b1011, seg_tab[9], 8);
    idle_wait(TIMEOUT + 200);
    check("timeout_digits_kept", digits, 16'h1234);
    hold_pair(4'b1110, seg_tab[5], 8);
    hold_pair(4'b1110, seg_tab[7], 8);
    hold_pair(4'b1101, seg_tab[0], 8);
    hold_pair(4'b1011, seg_tab[0], 8);
    hold_pair(4'b0111, seg_tab[0], 8);
    repeat (2) @(posedge clk);
    #1;
    check("recapture_digits", digits, 16'h0007);

    for (int r = 0; r < 40; r++) random_round();

    idle_wait(20);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
